// File: rtl/ram_bus_adapter.sv
// ram_bus_adapter
//   Converts a byte-addressed, byte-enabled req/ack host bus into the
//   word-addressed, whole-word port of a block RAM with one-cycle registered
//   reads (read-before-write) and no byte enables. Partial writes are done as
//   a read-modify-write: the word is read in the accept cycle and merged and
//   written back in the following cycle.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   host_req_i     request valid          host_we_i    1 = write, 0 = read
//   host_adr_i     byte address           host_be_i    write byte enables
//   host_wdata_i   write data             host_ack_o   request accepted
//   host_resp_o    read-data-valid pulse  host_rdata_o registered read data
//   ram_adr_o      RAM word address       ram_we_o     RAM write enable
//   ram_dat_o      RAM write data         ram_dat_i    RAM read data
//
// state | meaning
// IDLE  | accepting requests; RAM port driven straight from the host bus
// RD    | read data arriving from RAM; captured into host_rdata_o
// RMW   | old word arriving from RAM; merged with latched bytes and written

module ram_bus_adapter #(
  parameter int dat_width = 32,
  parameter int adr_width = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_req_i,
  input  logic                   host_we_i,
  input  logic [adr_width-1:0]   host_adr_i,
  input  logic [dat_width/8-1:0] host_be_i,
  input  logic [dat_width-1:0]   host_wdata_i,
  output logic                   host_ack_o,
  output logic                   host_resp_o,
  output logic [dat_width-1:0]   host_rdata_o,
  output logic [adr_width-1:0]   ram_adr_o,
  output logic                   ram_we_o,
  output logic [dat_width-1:0]   ram_dat_o,
  input  logic [dat_width-1:0]   ram_dat_i
);

  localparam int nbytes   = dat_width / 8;
  localparam int off_bits = $clog2(nbytes);

  typedef enum logic [1:0] {IDLE, RD, RMW} state_t;

  state_t                 state;
  logic [adr_width-1:0]   adr_q;
  logic [nbytes-1:0]      be_q;
  logic [dat_width-1:0]   wdata_q;

  logic [adr_width-1:0]   host_word_adr;
  logic                   be_full;
  logic                   be_none;

  assign host_word_adr = host_adr_i >> off_bits;
  assign be_full       = &host_be_i;
  assign be_none       = ~|host_be_i;
  assign host_ack_o    = host_req_i & (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      adr_q        <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      host_resp_o  <= 1'b0;
      host_rdata_o <= '0;
    end else begin
      host_resp_o <= 1'b0;
      case (state)
        IDLE: begin
          if (host_req_i) begin
            if (!host_we_i) begin
              adr_q <= host_word_adr;
              state <= RD;
            end else if (!be_full && !be_none) begin
              adr_q   <= host_word_adr;
              be_q    <= host_be_i;
              wdata_q <= host_wdata_i;
              state   <= RMW;
            end
            // Full writes complete in the accept cycle; be == 0 is a no-op.
          end
        end
        RD: begin
          host_rdata_o <= ram_dat_i;
          host_resp_o  <= 1'b1;
          state        <= IDLE;
        end
        RMW: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In IDLE the RAM sees the host request directly, so a read or the first
  // half of a read-modify-write is issued in the accept cycle itself.
  always_comb begin
    ram_adr_o = host_word_adr;
    ram_dat_o = host_wdata_i;
    ram_we_o  = 1'b0;
    case (state)
      IDLE: begin
        ram_we_o = host_req_i & host_we_i & be_full;
      end
      RD: begin
        ram_adr_o = adr_q;
      end
      RMW: begin
        ram_adr_o = adr_q;
        ram_we_o  = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
          ram_dat_o[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : ram_dat_i[8*k +: 8];
        end
      end
      default: begin
        ram_adr_o = host_word_adr;
      end
    endcase
  end

endmodule

// File: doc/ram_bus_adapter.md
# ram_bus_adapter

Front-end for one port of the dual-port block RAM. It converts a byte-addressed, byte-enabled req/ack host bus into the RAM's word-addressed, whole-word port. The RAM has one-cycle registered reads with read-before-write and no byte enables, so partial writes are done as a read-modify-write sequence. One instance sits directly upstream of each RAM port used by a core's instruction or data bus.

## Interface
- dat_width, 32: data width in bits; a multiple of 8; dat_width/8 is a power of two.
- adr_width, 32: width of the host byte address and the RAM word address.
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- host_req_i  in  1: host request valid.
- host_we_i  in  1: 1 = write, 0 = read.
- host_adr_i  in  adr_width: byte address; low log2(dat_width/8) bits are ignored.
- host_be_i  in  dat_width/8: byte enables for writes; ignored for reads.
- host_wdata_i  in  dat_width: write data.
- host_ack_o  out  1: request accepted this cycle.
- host_resp_o  out  1: one-cycle read-data-valid pulse.
- host_rdata_o  out  dat_width: read data, registered.
- ram_adr_o  out  adr_width: word address, equal to the byte address shifted right by log2(dat_width/8).
- ram_we_o  out  1: RAM write enable.
- ram_dat_o  out  dat_width: RAM write data.
- ram_dat_i  in  dat_width: RAM read data, valid one cycle after its address is presented.

## Operation
- FSM states: IDLE, RD, RMW.
- host_ack_o = host_req_i while in IDLE; otherwise 0. A request is accepted only on a cycle with ack = 1.
- IDLE drives the RAM combinationally:
  - ram_adr_o = word address of host_adr_i.
  - ram_dat_o = host_wdata_i.
  - ram_we_o = host_req_i & host_we_i & (host_be_i all ones).
- Accepted full write (be all ones): written to the RAM in the accept cycle; stay in IDLE; no resp.
- Accepted write with be == 0: no RAM write, no resp; stay in IDLE.
- Accepted read: latch the word address; go to RD.
- Accepted partial write: latch word address, be and wdata; go to RMW.
- RD:
  - ram_adr_o = latched address; ram_we_o = 0.
  - At the clock edge, host_rdata_o <= ram_dat_i and host_resp_o <= 1; go to IDLE.
- RMW:
  - ram_adr_o = latched address.
  - ram_dat_o byte k = latched wdata byte k if latched be[k], else ram_dat_i byte k.
  - ram_we_o = 1; go to IDLE.
- host_resp_o is 1 for exactly one cycle per read; host_rdata_o holds its value until the next read response.
- No guard against the other RAM port writing the same word between the RMW read and its write-back; that update is lost. This is a system-level rule: no concurrent partial writes to shared words.

## Timing
- Reset (asynchronous): state = IDLE, host_resp_o = 0, host_rdata_o = 0, latched registers = 0.
  - Combinational outputs follow IDLE immediately, so ram_we_o falls with rst when host_req_i is low.
- Reset asserted in RD or RMW discards the operation: no resp, no write-back.
- Read: ack in cycle T; resp and rdata valid in T+2; next request can be acked in T+1's successor (T+2). Throughput is one read per 2 cycles.
- Full write: ack and RAM write in cycle T. Back-to-back full writes run at one per cycle.
- Partial write: ack in T, write-back in T+1, next ack possible in T+2.
- Read-after-write: a read acked in the cycle after a full write to the same word returns the new data.
- Resp for a read acked in T overlaps a new request's ack in T+2; the host must sample resp independently of ack.

## Test plan
- Reset then read at byte address 0x10, RAM word 4 = 0xDEADBEEF → ack in T, host_resp_o = 1 and host_rdata_o = 0xDEADBEEF in T+2 only, ram_we_o = 0 throughout.
- Full write of 0x12345678 to 0x20, then read 0x20 in the next cycle → ram_we_o = 1 in the write cycle with ram_adr_o = 8; read returns 0x12345678.
- Word 8 = 0xAABBCCDD; partial write be = 4'b0101, wdata = 0x11223344 to 0x22 → ram_we_o = 1 in T+1 with ram_dat_o = 0xAA22CC44; readback is 0xAA22CC44.
- Write with be = 0 to word 8 → ack in the accept cycle, ram_we_o stays 0, word 8 unchanged.
- host_req_i held high with alternating read/full-write/read → acks only in IDLE cycles; one resp per read; no request lost or duplicated.
- rst pulsed in RMW state → ram_we_o = 0 during and after reset, the word is unchanged, host_resp_o = 0, and the next request is acked in the first cycle after reset is released.
